adres_rotating_rf: RTL and testbench

Four-entry, 32-bit rotating register file that sits beside an ADRES-style PE in the CGRA fabric. It consumes the PE ALU result (`rf_out`) and drives the PE's two RF return paths: port A feeds the operand-A mux (`rf_in_muxa`) and port B feeds the output mux (`rf_in_muxout`). Read/write addresses, write enable and the initiation interval (II) are static, loaded through the bit-serial configuration chain. An optional rotation feature renames registers once per II for modulo-scheduled loops.

---
 rtl/adres_rotating_rf.sv | 118 +++++++++++
 tb/tb_adres_rotating_rf.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adres_rotating_rf.sv
// adres_rotating_rf: four-entry, WIDTH-bit rotating register file placed next
// to an ADRES-style PE. Write/read addresses, write enable and the initiation
// interval come from an 11-bit bit-serial configuration chain:
//   cfg[1:0] wr_addr, cfg[2] wr_en, cfg[4:3] rda_addr, cfg[6:5] rdb_addr,
//   cfg[10:7] ii.
// Optional feature macro: ADRES_RF_ROTATE_EN. When it is defined, a cycle
// counter renames the registers once per II (base advances). Without it,
// base is fixed at 0 and the ii field is carried in the chain but unused.
// Reads are combinational from the stored array, with no write bypass.
module adres_rotating_rf #(
   parameter int WIDTH = 32
) (
   input  logic             CGRA_Clock,
   input  logic             CGRA_Reset,
   input  logic             Config_Enable,
   input  logic             ConfigIn,
   output logic             ConfigOut,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b
);

   logic [10:0]      cfg_r;
   logic [WIDTH-1:0] rf_r [4];
   logic [1:0]       base_s;
   logic [1:0]       wr_addr_s;
   logic             wr_en_s;
   logic [1:0]       rda_addr_s;
   logic [1:0]       rdb_addr_s;

   // Logical-to-physical register index under the current rotation base.
   function automatic logic [1:0] phys_idx(input logic [1:0] logical,
                                           input logic [1:0] base);
      return logical - base;
   endfunction

   assign wr_addr_s  = cfg_r[1:0];
   assign wr_en_s    = cfg_r[2];
   assign rda_addr_s = cfg_r[4:3];
   assign rdb_addr_s = cfg_r[6:5];
   assign ConfigOut  = cfg_r[10];

   // Configuration shift register; the first bit shifted in ends in cfg_r[10].
   always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
      if (!CGRA_Reset) begin
         cfg_r <= 11'd0;
      end else if (Config_Enable) begin
         cfg_r <= {cfg_r[9:0], ConfigIn};
      end else begin
         cfg_r <= cfg_r;
      end
   end

`ifdef ADRES_RF_ROTATE_EN
   logic [3:0] cyc_r;
   logic [1:0] base_r;
   logic [3:0] ii_eff_s;
   logic       wrap_s;

   // Effective II (ii of 0 behaves as 1) and end-of-iteration detect.
   always_comb begin
      ii_eff_s = 4'd1;
      wrap_s   = 1'b0;
      if (cfg_r[10:7] == 4'd0) begin
         ii_eff_s = 4'd1;
      end else begin
         ii_eff_s = cfg_r[10:7];
      end
      wrap_s = (cyc_r == (ii_eff_s - 4'd1));
   end

   // Iteration counter and rotation base; both freeze while configuring.
   always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
      if (!CGRA_Reset) begin
         cyc_r  <= 4'd0;
         base_r <= 2'd0;
      end else if (!Config_Enable) begin
         if (wrap_s) begin
            cyc_r  <= 4'd0;
            base_r <= base_r + 2'd1;
         end else begin
            cyc_r  <= cyc_r + 4'd1;
            base_r <= base_r;
         end
      end else begin
         cyc_r  <= cyc_r;
         base_r <= base_r;
      end
   end

   assign base_s = base_r;
`else
   assign base_s = 2'd0;
`endif

   // Register array write; the index uses the base in effect before the edge,
   // so a write coinciding with a rotate lands at the pre-rotate slot.
   always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
      if (!CGRA_Reset) begin
         for (int i = 0; i < 4; i++) begin
            rf_r[i] <= '0;
         end
      end else if (!Config_Enable && wr_en_s) begin
         rf_r[phys_idx(wr_addr_s, base_s)] <= in;
      end else begin
         for (int i = 0; i < 4; i++) begin
            rf_r[i] <= rf_r[i];
         end
      end
   end

   // Combinational read ports through the rotation mapping.
   always_comb begin
      out_a = rf_r[phys_idx(rda_addr_s, base_s)];
      out_b = rf_r[phys_idx(rdb_addr_s, base_s)];
   end

endmodule

// File: tb/tb_adres_rotating_rf.sv
// Self-checking bench for adres_rotating_rf: table-driven write/read vectors,
// hand-written multi-cycle sequences, and a scoreboard queue of expected
// read-port values that is popped after each active edge.
module tb_adres_rotating_rf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_en;
   logic        cfg_in;
   logic        cfg_out;
   logic [31:0] din;
   logic [31:0] out_a;
   logic [31:0] out_b;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       name;
      logic [31:0] ea;
      logic [31:0] eb;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [1:0]  wa;
      logic        we;
      logic [1:0]  ra;
      logic [1:0]  rb;
      logic [31:0] d;
      logic [31:0] pre_a;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;
   vec_t vecs[8];

   // Reference model state
   logic [31:0] m_rf [4];
   logic [1:0]  m_base;
   logic [10:0] m_cfg;
`ifdef ADRES_RF_ROTATE_EN
   logic [3:0]  m_cyc;
`endif

   always #5 clk = ~clk;

   adres_rotating_rf #(.WIDTH(32)) dut (
      .CGRA_Clock   (clk),
      .CGRA_Reset   (rst_n),
      .Config_Enable(cfg_en),
      .ConfigIn     (cfg_in),
      .ConfigOut    (cfg_out),
      .in           (din),
      .out_a        (out_a),
      .out_b        (out_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input string name, input logic [31:0] ea, input logic [31:0] eb);
      exp_t e;
      e.name = name;
      e.ea   = ea;
      e.eb   = eb;
      sb_q.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sb_q.pop_front();
         check({e.name, "_a"}, out_a, e.ea);
         check({e.name, "_b"}, out_b, e.eb);
      end
   endtask

   // Called at a negedge; leaves the bench at the following negedge.
   task automatic clock_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic shift_word(input logic [10:0] w);
      cfg_en = 1'b1;
      din    = 32'hFFFF_FFFF;
      for (int i = 10; i >= 0; i--) begin
         cfg_in = w[i];
         clock_cycle();
      end
      cfg_en = 1'b0;
      cfg_in = 1'b0;
      m_cfg  = w;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      din    = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         cfg_en = 1'($urandom_range(1, 0));
         cfg_in = 1'($urandom_range(1, 0));
         clock_cycle();
         check("reset_out_a", out_a, 32'h0);
         check("reset_out_b", out_b, 32'h0);
         check("reset_cfgout", 32'(cfg_out), 32'h0);
      end
      rst_n  = 1'b1;
      cfg_en = 1'b0;
      cfg_in = 1'b0;
      for (int i = 0; i < 4; i++) m_rf[i] = 32'h0;
      m_base = 2'd0;
      m_cfg  = 11'd0;
`ifdef ADRES_RF_ROTATE_EN
      m_cyc  = 4'd0;
`endif
   endtask

   // One non-config cycle with expectations derived from the reference model.
   task automatic step(input string name, input logic [31:0] d);
      logic [1:0] wa, ra, rb;
      wa  = m_cfg[1:0];
      ra  = m_cfg[4:3];
      rb  = m_cfg[6:5];
      din = d;
      if (m_cfg[2]) m_rf[2'(wa - m_base)] = d;
`ifdef ADRES_RF_ROTATE_EN
      begin
         logic [3:0] ii_eff;
         ii_eff = (m_cfg[10:7] == 4'd0) ? 4'd1 : m_cfg[10:7];
         if (m_cyc == ii_eff - 4'd1) begin
            m_cyc  = 4'd0;
            m_base = m_base + 2'd1;
         end else begin
            m_cyc  = m_cyc + 4'd1;
         end
      end
`endif
      push_exp(name, m_rf[2'(ra - m_base)], m_rf[2'(rb - m_base)]);
      clock_cycle();
      pop_check();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [10:0] w1, w2;
      logic [31:0] se_a[4];
      logic [31:0] se_b[4];

      vecs[0] = '{2'd0, 1'b1, 2'd0, 2'd1, 32'h1111_1111, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000};
      vecs[1] = '{2'd1, 1'b1, 2'd0, 2'd1, 32'h2222_2222, 32'h1111_1111, 32'h1111_1111, 32'h2222_2222};
      vecs[2] = '{2'd2, 1'b1, 2'd2, 2'd3, 32'h3333_3333, 32'h0000_0000, 32'h3333_3333, 32'h0000_0000};
      vecs[3] = '{2'd3, 1'b1, 2'd3, 2'd2, 32'h4444_4444, 32'h0000_0000, 32'h4444_4444, 32'h3333_3333};
      vecs[4] = '{2'd0, 1'b0, 2'd0, 2'd3, 32'hFFFF_FFFF, 32'h1111_1111, 32'h1111_1111, 32'h4444_4444};
      vecs[5] = '{2'd1, 1'b1, 2'd1, 2'd1, 32'hA5A5_A5A5, 32'h2222_2222, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
      vecs[6] = '{2'd2, 1'b0, 2'd2, 2'd0, 32'h5A5A_5A5A, 32'h3333_3333, 32'h3333_3333, 32'h1111_1111};
      vecs[7] = '{2'd0, 1'b1, 2'd3, 2'd0, 32'hDEAD_BEEF, 32'h4444_4444, 32'h4444_4444, 32'hDEAD_BEEF};

      rst_n  = 1'b0;
      cfg_en = 1'b0;
      cfg_in = 1'b0;
      din    = 32'h0;
      @(negedge clk);

      // Reset, then release: outputs remain 0 without a configured write
      do_reset();
      step("post_reset0", 32'hDEAD_BEEF);
      step("post_reset1", 32'hDEAD_BEEF);

      // Config chain: load w1, then shifting w2 replays w1 on ConfigOut MSB first
      do_reset();
      w1 = {4'd0, 2'd1, 2'd2, 1'b1, 2'd2};
      w2 = {4'd0, 2'd0, 2'd1, 1'b1, 2'd1};
      shift_word(w1);
      cfg_en = 1'b1;
      for (int i = 10; i >= 0; i--) begin
         check($sformatf("cfgout_bit%0d", i), 32'(cfg_out), 32'(w1[i]));
         cfg_in = w2[i];
         clock_cycle();
      end
      cfg_en = 1'b0;
      cfg_in = 1'b0;
      m_cfg  = w2;
      for (int i = 0; i < 4; i++) step($sformatf("w2_step%0d", i), 32'h1000 + 32'(i));

      // Table-driven write/read with ii=15 (no rotation inside the run)
      do_reset();
      for (int i = 0; i < 8; i++) begin
         shift_word({4'd15, vecs[i].rb, vecs[i].ra, vecs[i].we, vecs[i].wa});
         din = vecs[i].d;
         check($sformatf("vec%0d_pre_a", i), out_a, vecs[i].pre_a);
         push_exp($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b);
         clock_cycle();
         pop_check();
      end

      // Writes suppressed while shifting with wr_en set and in all ones
      shift_word({4'd15, 2'd2, 2'd1, 1'b1, 2'd0});
      check("suppress_a", out_a, 32'hA5A5_A5A5);
      check("suppress_b", out_b, 32'h3333_3333);

`ifdef ADRES_RF_ROTATE_EN
      // Rotation with ii=2: base advances every second edge
      do_reset();
      shift_word({4'd2, 2'd0, 2'd1, 1'b1, 2'd0});
      step("rot_c0", 32'h0000_000A);
      step("rot_c1", 32'h0000_000A);
      check("rot_a_after_base1", out_a, 32'h0000_000A);
      for (int i = 2; i < 9; i++) step($sformatf("rot_c%0d", i), 32'h100 + 32'(i));

      // Same-edge write and rotate with ii=1
      do_reset();
      shift_word({4'd1, 2'd0, 2'd3, 1'b1, 2'd0});
      se_a = '{32'h0, 32'h0, 32'h1, 32'h2};
      se_b = '{32'h0, 32'h0, 32'h0, 32'h1};
      for (int i = 0; i < 4; i++) begin
         din = 32'(i + 1);
         push_exp($sformatf("same_edge%0d", i), se_a[i], se_b[i]);
         clock_cycle();
         pop_check();
      end
`else
      // Default build: physical equals logical regardless of ii
      do_reset();
      shift_word({4'd1, 2'd0, 2'd3, 1'b1, 2'd3});
      step("norot0", 32'h0BAD_F00D);
      check("norot_a", out_a, 32'h0BAD_F00D);
      step("norot1", 32'h1234_5678);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
